pixel_tx_packer: RTL and testbench

Output-side counterpart of the bicubic control_unit's 64-bit input packing. Takes the interpolated pixel stream (32-bit signed pixel, one per valid cycle), clamps each pixel to 8 bits and packs 8 pixels per 64-bit word. Sends the words to the host over a RIFFA TX channel with the req/ack and data_valid/data_ren handshakes. Sits between control_unit's pixel_out/output_valid and the RIFFA TX endpoint.

---
 rtl/pixel_tx_packer.sv | 139 +++++++++++++
 tb/tb_pixel_tx_packer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_tx_packer.sv
// rtl/pixel_tx_packer.sv - clamps 32-bit pixels to bytes, packs 8 per word, streams words over a RIFFA TX channel
module pixel_tx_packer #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [30:0] TX_OFF     = 31'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] out_rows,
    input  logic [31:0] out_cols,
    input  logic [31:0] pixel_in,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic        tx,
    input  logic        tx_ack,
    output logic        tx_last,
    output logic [31:0] tx_len,
    output logic [30:0] tx_off,
    output logic [63:0] tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ren,
    output logic        busy,
    output logic        done,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_STREAM, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   total_pix_q, total_words_q, tx_len_q, pix_cnt_q, word_cnt_q;
    logic [2:0]    lane_q;
    logic [63:0]   word_q;
    logic          overflow_q;
    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic [31:0] prod, words;
    logic [7:0]  pix_byte;
    logic [63:0] word_next;
    logic        start_ok, accept, drop, push, pop, last_pix, last_word;

    assign prod  = out_rows * out_cols;
    assign words = 32'(({1'b0, prod} + 33'd7) >> 3);

    // Negative -> 0, anything above 255 -> 255
    assign pix_byte  = pixel_in[31] ? 8'h00 : (|pixel_in[30:8] ? 8'hFF : pixel_in[7:0]);
    assign word_next = word_q | ({56'd0, pix_byte} << {lane_q, 3'b000});

    assign busy          = (state_q != S_IDLE);
    assign pixel_ready   = busy && (count_q < CW'(FIFO_DEPTH - 1)) && (pix_cnt_q < total_pix_q);
    assign accept        = pixel_valid && pixel_ready;
    assign drop          = pixel_valid && busy && !pixel_ready;
    assign last_pix      = (pix_cnt_q + 32'd1) == total_pix_q;
    assign push          = accept && ((lane_q == 3'd7) || last_pix);
    assign tx_data_valid = (state_q == S_STREAM) && (count_q != '0);
    assign pop           = tx_data_valid && tx_data_ren;
    assign last_word     = (word_cnt_q + 32'd1) == total_words_q;
    assign start_ok      = (state_q == S_IDLE) && start;

    // Gated so the data bus reads zero while nothing is offered (incl. reset)
    assign tx_data  = tx_data_valid ? mem_q[rd_ptr_q] : 64'd0;
    assign tx_len   = tx_len_q;
    assign tx_off   = TX_OFF;
    assign tx_last  = 1'b1;
    assign overflow = overflow_q;

    always_comb begin
        state_d = state_q;
        tx      = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE:   if (start) state_d = S_REQ;
            S_REQ: begin
                tx = 1'b1;
                if (tx_ack) state_d = S_STREAM;
            end
            S_STREAM: begin
                tx = 1'b1;
                if (pop && last_word) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            total_pix_q   <= '0;
            total_words_q <= '0;
            tx_len_q      <= '0;
            pix_cnt_q     <= '0;
            word_cnt_q    <= '0;
            lane_q        <= '0;
            word_q        <= '0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                total_pix_q   <= prod;
                total_words_q <= words;
                tx_len_q      <= words << 1;
                pix_cnt_q     <= '0;
                word_cnt_q    <= '0;
                lane_q        <= '0;
                word_q        <= '0;
                overflow_q    <= 1'b0;
            end else begin
                if (drop) overflow_q <= 1'b1;
                if (accept) begin
                    pix_cnt_q <= pix_cnt_q + 32'd1;
                    lane_q    <= push ? 3'd0 : lane_q + 3'd1;
                    word_q    <= push ? 64'd0 : word_next;
                end
                if (pop) word_cnt_q <= word_cnt_q + 32'd1;
            end
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= word_next;
    end
endmodule

// File: tb/tb_pixel_tx_packer.sv
// tb/tb_pixel_tx_packer.sv - randomized scoreboard bench for pixel_tx_packer
module tb_pixel_tx_packer;
    logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic [31:0] out_rows = '0, out_cols = '0, pixel_in = '0;
    logic        pixel_valid = 1'b0, pixel_ready, tx, tx_ack = 1'b0, tx_last;
    logic [31:0] tx_len;
    logic [30:0] tx_off;
    logic [63:0] tx_data;
    logic        tx_data_valid, tx_data_ren = 1'b0, busy, done, overflow;

    pixel_tx_packer #(.FIFO_DEPTH(16), .TX_OFF(31'd0)) dut (
        .clock(clock), .reset(reset), .start(start), .out_rows(out_rows), .out_cols(out_cols),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .tx(tx), .tx_ack(tx_ack), .tx_last(tx_last), .tx_len(tx_len), .tx_off(tx_off),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ren(tx_data_ren),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0, n_bad = 0;
    logic [63:0] exp_q[$];
    int          done_cnt = 0, beats = 0;
    int          ack_delay = 3, ren_mode = 1, ack_cnt = 0;
    bit          acked = 0, hold_chk = 0;
    logic [63:0] hold_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] clamp8(input int p);
        if (p < 0) return 8'h00;
        if (p > 255) return 8'hFF;
        return p[7:0];
    endfunction

    // Reference: every 8 consecutive pixels form one word, first pixel in the low byte
    task automatic build_words(input int pix[$]);
        for (int i = 0; i < pix.size(); i += 8) begin
            logic [63:0] w = '0;
            for (int k = 0; k < 8; k++)
                if (i + k < pix.size()) w[8*k +: 8] = clamp8(pix[i+k]);
            exp_q.push_back(w);
        end
    endtask

    always @(negedge clock) begin
        if (done) done_cnt++;
        if (hold_chk && tx_data_valid) check("tx_data_hold", tx_data, hold_data);
        hold_chk  = tx_data_valid && !tx_data_ren;
        hold_data = tx_data;
        if (tx_data_valid && tx_data_ren) begin
            beats++;
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_beat: got %h expected none", tx_data);
            end else check("tx_data", tx_data, exp_q.pop_front());
        end
    end

    initial forever begin
        @(posedge clock); #1;
        tx_ack = 1'b0;
        if (!tx) begin ack_cnt = 0; acked = 0; end
        else if (!acked) begin
            ack_cnt++;
            if (ack_cnt >= ack_delay) begin tx_ack = 1'b1; acked = 1; end
        end
    end

    initial forever begin
        @(posedge clock); #1;
        case (ren_mode)
            0:       tx_data_ren = 1'b0;
            1:       tx_data_ren = 1'b1;
            default: tx_data_ren = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic do_start(input int r, input int c);
        out_rows = r; out_cols = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_pixels(input int pix[$], input int stop_beats);
        int i = 0, guard = 0, b0 = beats;
        while (i < pix.size()) begin
            if (stop_beats > 0 && beats - b0 >= stop_beats) break;
            if (pixel_ready && $urandom_range(0, 3) != 0) begin
                pixel_valid = 1'b1; pixel_in = pix[i]; i++;
            end else pixel_valid = 1'b0;
            tick();
            guard++;
            if (guard > 40000) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: got %0d pixels sent expected %0d", i, pix.size());
                break;
            end
        end
        pixel_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int c = 0;
        while (done_cnt == d0 && c < 40000) begin tick(); c++; end
        repeat (3) tick();
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_image(input int r, input int c, input int pix[$], input bit restart);
        int d0 = done_cnt, b0 = beats;
        int nw = (r * c + 7) / 8;
        build_words(pix);
        do_start(r, c);
        if (restart) begin
            out_rows = 50; out_cols = 50; start = 1'b1; tick(); start = 1'b0;
        end
        check("tx_len", 64'(tx_len), 64'(2 * nw));
        check("tx_busy", 64'({busy, tx, tx_last}), 64'b111);
        send_pixels(pix, 0);
        wait_done(d0);
        check("beats", 64'(beats - b0), 64'(nw));
        check("overflow_clean", 64'(overflow), 64'd0);
        check("tx_len_held", 64'(tx_len), 64'(2 * nw));
    endtask

    initial begin
        int pix[$];
        int pix2[$];
        int r, c, d0;

        repeat (3) tick();
        check("rst_outputs", {busy, done, overflow, tx, tx_data_valid, pixel_ready}, 64'd0);
        check("rst_tx_len", 64'(tx_len), 64'd0);
        check("rst_tx_data", tx_data, 64'd0);
        reset = 1'b0;
        tick();

        repeat (4) begin pixel_valid = 1'b1; pixel_in = $urandom; tick(); end
        pixel_valid = 1'b0;
        check("idle_pixels", 64'({overflow, busy, pixel_ready}), 64'd0);

        pix = {};
        for (int i = 1; i <= 9; i++) pix.push_back(i);
        run_image(3, 3, pix, 1'b1);

        pix = '{-5, 300, 255, 0, 128, -1, 256, 17};
        run_image(1, 8, pix, 1'b0);

        for (int t = 0; t < 4; t++) begin
            ren_mode = 2; ack_delay = $urandom_range(0, 4);
            r = $urandom_range(1, 12); c = $urandom_range(1, 12);
            pix = {};
            for (int i = 0; i < r * c; i++) pix.push_back(int'($urandom_range(0, 600)) - 150);
            run_image(r, c, pix, 1'b0);
        end

        ren_mode = 1; ack_delay = 3;
        pix = {};
        for (int i = 0; i < 16384; i++) pix.push_back(i % 256);
        run_image(128, 128, pix, 1'b0);

        ren_mode = 0; ack_delay = 1;
        pix = {}; pix2 = {};
        for (int i = 0; i < 125; i++) pix.push_back(int'($urandom_range(0, 255)));
        for (int i = 0; i < 136; i++) pix2.push_back(int'($urandom_range(0, 255)));
        for (int i = 0; i < 120; i++) exp_q.push_back(64'd0);
        repeat (120) void'(exp_q.pop_back());
        begin
            int all[$];
            all = {};
            for (int i = 0; i < 120; i++) all.push_back(pix[i]);
            for (int i = 0; i < 136; i++) all.push_back(pix2[i]);
            build_words(all);
        end
        d0 = done_cnt;
        do_start(16, 16);
        for (int i = 0; i < 125; i++) begin
            if (i == 119) check("bp_ready_before", 64'(pixel_ready), 64'd1);
            if (i == 120) check("bp_ready_full", 64'(pixel_ready), 64'd0);
            pixel_valid = 1'b1; pixel_in = pix[i];
            tick();
        end
        pixel_valid = 1'b0;
        check("bp_overflow", 64'(overflow), 64'd1);
        check("bp_offered", 64'({tx_data_valid, pixel_ready}), 64'b10);
        ren_mode = 1;
        send_pixels(pix2, 0);
        wait_done(d0);
        check("bp_overflow_sticky", 64'(overflow), 64'd1);

        ack_delay = 3;
        pix = {};
        for (int i = 0; i < 16384; i++) pix.push_back(int'($urandom_range(0, 255)));
        build_words(pix);
        d0 = done_cnt;
        do_start(128, 128);
        send_pixels(pix, 100);
        #2 reset = 1'b1;
        #1;
        check("async_rst_outputs", {busy, done, overflow, tx, tx_data_valid, pixel_ready}, 64'd0);
        check("async_rst_data", {tx_data}, 64'd0);
        check("async_rst_len", 64'(tx_len), 64'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("no_done_on_abort", 64'(done_cnt - d0), 64'd0);

        pix = {};
        for (int i = 0; i < 9; i++) pix.push_back(int'($urandom_range(0, 255)));
        run_image(3, 3, pix, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
